// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel button/switch debouncer.
// Each channel has a flop synchroniser, a consecutive-mismatch counter compared
// against the shared runtime threshold cnt_limit, a debounced state, and
// one-cycle press/release pulses.
// Optional long-press detection is compiled in when DEBOUNCE_LONG_PRESS_EN is
// defined. Otherwise long_press is tied low and HOLD_CYCLES has no effect.
// All logic is on posedge clk with a synchronous, active-high rst.
module multi_debouncer #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  buttons_in,
    input  logic [CNT_W-1:0] cnt_limit,
    output logic [N_CH-1:0]  button_state,
    output logic [N_CH-1:0]  press_pulse,
    output logic [N_CH-1:0]  release_pulse,
    output logic [N_CH-1:0]  long_press
);

    // Synchroniser: stage 0 samples the raw pins; the last stage feeds the debouncer.
    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync_d [SYNC_STAGES];
    logic [N_CH-1:0]  sync_last;

    // Debounce state per channel.
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  state_q, state_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  release_q, release_d;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Shift each channel's raw input one stage deeper into the synchroniser.
    always_comb begin
        sync_d[0] = buttons_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Count consecutive mismatches. Once the count reaches the threshold, flip the state and pulse.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (sync_last[i] != state_q[i]) begin
                // >= rather than ==, so a counter left above a newly lowered limit
                // still toggles on its next mismatching cycle.
                if (cnt_q[i] >= cnt_limit) begin
                    state_d[i]   = ~state_q[i];
                    press_d[i]   = ~state_q[i];
                    release_d[i] = state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register the synchroniser, the counters, the debounced state and the pulses.
    always_ff @(posedge clk) begin
        // NOTE: the counter and synchroniser arrays sit in ordinary flops, not RAM,
        // so they are cleared element by element along with the rest of the state.
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < N_CH; i++)        cnt_q[i]  <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the
            // pre-edge value of its neighbours, as real flip-flops do.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
            for (int i = 0; i < N_CH; i++)        cnt_q[i]  <= cnt_d[i];
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign button_state  = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    // Hold counter wide enough to reach HOLD_CYCLES. It saturates there, so one press fires at most once.
    localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q [N_CH];
    logic [HOLD_W-1:0] hold_d [N_CH];
    logic [N_CH-1:0]   long_q, long_d;

    // Count cycles spent in the pressed state. Fire when the count reaches HOLD_CYCLES.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i] = '0;
            if (state_q[i]) begin
                hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + HOLD_W'(1);
                long_d[i] = (hold_q[i] == HOLD_FIRE);
            end
        end
    end

    // Register the hold counters and the long-press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
            long_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = {N_CH{1'b0}};
`endif

endmodule
